// File: rtl/riscv_bp_gshare_if.sv
// Lookup/update bundle between fetch/branch unit (master) and the gshare table (slave).
interface riscv_bp_gshare_if #(
    parameter int XLEN           = 32,
    parameter int BP_GLOBAL_BITS = 2
);
    logic                      if_stall;
    logic [XLEN-1:0]           if_pc;
    logic [BP_GLOBAL_BITS-1:0] bu_bp_history;
    logic [XLEN-1:0]           ex_pc;
    logic                      bu_bp_update;
    logic                      bu_bp_btaken;
    logic [1:0]                bu_bp_predict;
    logic [1:0]                bp_bp_predict;
    logic                      bp_ready;
    logic [31:0]               bp_stat_updates;
    logic [31:0]               bp_stat_mispred;

    modport master (
        output if_stall, if_pc, bu_bp_history, ex_pc, bu_bp_update, bu_bp_btaken, bu_bp_predict,
        input  bp_bp_predict, bp_ready, bp_stat_updates, bp_stat_mispred
    );

    modport slave (
        input  if_stall, if_pc, bu_bp_history, ex_pc, bu_bp_update, bu_bp_btaken, bu_bp_predict,
        output bp_bp_predict, bp_ready, bp_stat_updates, bp_stat_mispred
    );
endinterface

// File: rtl/riscv_bp_gshare.sv
// Gshare predictor: 2-bit counters indexed by {history, PC bits}; 1-cycle lookup, write-first bypass.
// Table is swept to weak-not-taken after reset (DEPTH cycles); optional BP_STATS_EN adds update/mispredict counters.
module riscv_bp_gshare #(
    parameter int XLEN           = 32,
    parameter int BP_GLOBAL_BITS = 2,
    parameter int BP_LOCAL_BITS  = 10,
    parameter int HAS_RVC        = 0
) (
    input  logic            clk,
    input  logic            rstn,
    riscv_bp_gshare_if.slave bp
);
    localparam int AW    = BP_GLOBAL_BITS + BP_LOCAL_BITS;
    localparam int DEPTH = 2 ** AW;
    localparam int OFS   = (HAS_RVC != 0) ? 1 : 2;

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]    r_state;
    logic [AW-1:0] r_sweep;
    logic          r_ready;
    logic [1:0]    r_pred;
    logic [1:0]    r_table [DEPTH];

    logic [AW-1:0] w_lookup_idx;
    logic [AW-1:0] w_update_idx;
    logic [1:0]    w_sat;
    logic          w_upd;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [1:0]    w_wdat;
    logic          w_unused_pc;

    assign w_lookup_idx = {bp.bu_bp_history, bp.if_pc[OFS+BP_LOCAL_BITS-1 -: BP_LOCAL_BITS]};
    assign w_update_idx = {bp.bu_bp_history, bp.ex_pc[OFS+BP_LOCAL_BITS-1 -: BP_LOCAL_BITS]};
    assign w_upd        = (r_state == S_RUN) && bp.bu_bp_update;
    assign w_unused_pc  = ^{bp.if_pc, bp.ex_pc};

    // Saturating step from the counter the branch was predicted with, not a table re-read.
    always_comb begin
        w_sat = bp.bu_bp_predict;
        if (bp.bu_bp_btaken) begin
            if (bp.bu_bp_predict != 2'b11) w_sat = bp.bu_bp_predict + 2'b01;
        end else begin
            if (bp.bu_bp_predict != 2'b00) w_sat = bp.bu_bp_predict - 2'b01;
        end
    end

    always_comb begin
        w_we    = 1'b0;
        w_waddr = w_update_idx;
        w_wdat  = w_sat;
        if (rstn) begin
            if (r_state == S_INIT) begin
                w_we    = 1'b1;
                w_waddr = r_sweep;
                w_wdat  = 2'b01;
            end else if (w_upd) begin
                w_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_table[w_waddr] <= w_wdat;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_INIT;
            r_sweep <= '0;
            r_ready <= 1'b0;
        end else if (r_state == S_INIT) begin
            r_sweep <= r_sweep + AW'(1);
            if (r_sweep == {AW{1'b1}}) begin
                r_state <= S_RUN;
                r_ready <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pred <= 2'b01;
        end else if (r_state == S_RUN && !bp.if_stall) begin
            r_pred <= (w_upd && (w_update_idx == w_lookup_idx)) ? w_sat : r_table[w_lookup_idx];
        end
    end

    assign bp.bp_bp_predict = r_pred;
    assign bp.bp_ready      = r_ready;

`ifdef BP_STATS_EN
    logic [31:0] r_stat_upd;
    logic [31:0] r_stat_mis;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_stat_upd <= '0;
            r_stat_mis <= '0;
        end else if (w_upd) begin
            if (r_stat_upd != 32'hFFFF_FFFF) r_stat_upd <= r_stat_upd + 32'd1;
            if ((bp.bu_bp_btaken != bp.bu_bp_predict[1]) && (r_stat_mis != 32'hFFFF_FFFF))
                r_stat_mis <= r_stat_mis + 32'd1;
        end
    end

    assign bp.bp_stat_updates = r_stat_upd;
    assign bp.bp_stat_mispred = r_stat_mis;
`else
    assign bp.bp_stat_updates = 32'd0;
    assign bp.bp_stat_mispred = 32'd0;
`endif
endmodule

// File: tb/tb_riscv_bp_gshare.sv
// Scoreboard bench for riscv_bp_gshare (GB=2, LB=4, DEPTH=64) against an array-based reference model.
module tb_riscv_bp_gshare;
    localparam int XLEN  = 32;
    localparam int GB    = 2;
    localparam int LB    = 4;
    localparam int DEPTH = 1 << (GB + LB);

    typedef struct {
        logic [1:0]  pred;
        logic        ready;
        logic [31:0] upd;
        logic [31:0] mis;
    } exp_t;

    logic clk;
    logic rstn;
    riscv_bp_gshare_if #(.XLEN(XLEN), .BP_GLOBAL_BITS(GB)) bif ();

    riscv_bp_gshare #(.XLEN(XLEN), .BP_GLOBAL_BITS(GB), .BP_LOCAL_BITS(LB), .HAS_RVC(0)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bp   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    exp_t scb[$];

    int          m_tab [DEPTH];
    int          m_init_left = 0;
    int          m_pred = 1;
    bit          m_ready = 0;
    longint      m_upd = 0;
    longint      m_mis = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int sat(input int p, input bit taken);
        if (taken) return (p >= 3) ? 3 : p + 1;
        return (p <= 0) ? 0 : p - 1;
    endfunction

    function automatic int idx_of(input int hist, input logic [31:0] pc);
        return hist * (1 << LB) + int'((pc >> 2) % (1 << LB));
    endfunction

    // Drive one cycle of inputs and push the response expected after the next rising edge.
    task automatic step(input bit rst_n, input bit stall, input logic [31:0] pc, input int hist,
                        input logic [31:0] epc, input bit upd, input bit bt, input int pr);
        exp_t e;
        int li, ui, nv;
        @(negedge clk);
        rstn               = rst_n;
        bif.if_stall       = stall;
        bif.if_pc          = pc;
        bif.bu_bp_history  = GB'(hist);
        bif.ex_pc          = epc;
        bif.bu_bp_update   = upd;
        bif.bu_bp_btaken   = bt;
        bif.bu_bp_predict  = 2'(pr);
        if (!rst_n) begin
            foreach (m_tab[i]) m_tab[i] = 1;
            m_init_left = DEPTH;
            m_pred      = 1;
            m_ready     = 0;
            m_upd       = 0;
            m_mis       = 0;
        end else if (m_init_left > 0) begin
            m_init_left--;
            m_ready = (m_init_left == 0);
        end else begin
            li = idx_of(hist, pc);
            ui = idx_of(hist, epc);
            nv = sat(pr, bt);
            if (!stall) m_pred = (upd && li == ui) ? nv : m_tab[li];
            if (upd) begin
                m_tab[ui] = nv;
                if (m_upd < 64'hFFFF_FFFF) m_upd++;
                if ((bt != pr[1]) && m_mis < 64'hFFFF_FFFF) m_mis++;
            end
        end
        e.pred  = 2'(m_pred);
        e.ready = m_ready;
`ifdef BP_STATS_EN
        e.upd = 32'(m_upd);
        e.mis = 32'(m_mis);
`else
        e.upd = 32'd0;
        e.mis = 32'd0;
`endif
        scb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 32'h0, 0, 32'h0, 0, 0, 1);
    endtask

    task automatic rand_cycle(input bit allow_upd);
        logic [31:0] pc, epc;
        pc  = ($urandom & 32'hFFFF_FFC0) | (32'($urandom_range(0, 15)) << 2);
        epc = ($urandom & 32'hFFFF_FFC0) | (32'($urandom_range(0, 15)) << 2);
        if ($urandom_range(0, 3) == 0) epc = pc;
        step(1, ($urandom_range(0, 3) == 0), pc, int'($urandom_range(0, 3)), epc,
             allow_upd && ($urandom_range(0, 1) == 1), $urandom_range(0, 1) == 1,
             int'($urandom_range(0, 3)));
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (scb.size() > 0) begin
            e = scb.pop_front();
            chk("predict", 32'(bif.bp_bp_predict), 32'(e.pred));
            chk("ready", 32'(bif.bp_ready), 32'(e.ready));
            chk("stat_updates", bif.bp_stat_updates, e.upd);
            chk("stat_mispred", bif.bp_stat_mispred, e.mis);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        bif.if_stall = 1'b0; bif.if_pc = '0; bif.bu_bp_history = '0; bif.ex_pc = '0;
        bif.bu_bp_update = 1'b0; bif.bu_bp_btaken = 1'b0; bif.bu_bp_predict = 2'b01;

        // Reset, then abort the sweep at entry 30 with updates attempted during INIT.
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 0, 32'h0, 1, 1, 3);
        for (int i = 0; i < 30; i++) rand_cycle(1);
        step(0, 0, 32'h0, 0, 32'h0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) rand_cycle(1);

        // Basic training, saturation at both ends.
        step(1, 0, 32'h104, 0, 32'h200, 1, 1, 1);
        step(1, 0, 32'h200, 0, 32'h0, 0, 0, 1);
        step(1, 0, 32'h0, 0, 32'h218, 1, 1, 3);
        step(1, 0, 32'h218, 0, 32'h01C, 1, 0, 0);
        step(1, 0, 32'h01C, 0, 32'h0, 0, 0, 1);

        // Same-cycle update and lookup of index 5.
        step(1, 0, 32'h014, 0, 32'h014, 1, 1, 1);
        idle(1);

        // Hold output for 3 stalled cycles, including a write to the held index.
        step(1, 0, 32'h014, 0, 32'h0, 0, 0, 1);
        step(1, 1, 32'h200, 0, 32'h014, 1, 1, 2);
        step(1, 1, 32'h218, 1, 32'h0, 0, 0, 1);
        step(1, 1, 32'h01C, 2, 32'h0, 0, 0, 1);
        step(1, 0, 32'h014, 0, 32'h0, 0, 0, 1);

        for (int i = 0; i < 300; i++) rand_cycle(1);

        // Fresh reset, then 5 updates of which 2 mispredict.
        step(0, 0, 32'h0, 0, 32'h0, 0, 0, 1);
        idle(DEPTH);
        step(1, 0, 32'h0, 0, 32'h040, 1, 1, 3);
        step(1, 0, 32'h0, 1, 32'h044, 1, 0, 0);
        step(1, 0, 32'h0, 2, 32'h048, 1, 0, 1);
        step(1, 0, 32'h0, 3, 32'h04C, 1, 0, 2);
        step(1, 0, 32'h0, 0, 32'h050, 1, 1, 1);
        idle(2);
        @(posedge clk);
        #2;
`ifdef BP_STATS_EN
        chk("final_updates", bif.bp_stat_updates, 32'd5);
        chk("final_mispred", bif.bp_stat_mispred, 32'd2);
`else
        chk("final_updates", bif.bp_stat_updates, 32'd0);
        chk("final_mispred", bif.bp_stat_mispred, 32'd0);
`endif
        chk("final_ready", 32'(bif.bp_ready), 32'd1);
        chk("scoreboard_drained", 32'(scb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
